car_link_tx: RTL

Serial transmitter that sends this board's car state to the peer board in two-player mode. The physics engine's collision-box centres, lap flag, finish bit and the current game state are snapshotted at a fixed frame rate. Each snapshot goes out as an 8-byte checksummed UART 8N1 packet on one TX pin. The peer's link receiver turns the packet back into its other_f_x/other_f_y/other_r_x/other_r_y inputs.

---
 rtl/car_link_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/car_link_tx.sv
`default_nettype none
// ============================================================================
// Module   : car_link_tx
// Purpose  : Snapshots own car state at the frame rate and sends it to the
//            peer board as an 8-byte checksummed UART 8N1 packet.
// Revision : 1.0 - initial release
// ============================================================================
module car_link_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FRAME_RATE = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic [9:0] my_f_x,
    input  logic [9:0] my_f_y,
    input  logic [9:0] my_r_x,
    input  logic [9:0] my_r_y,
    input  logic [1:0] flag,
    input  logic       finish,
    output logic       tx,
    output logic       busy,
    output logic       frame_sent,
    output logic       frame_drop
);

    localparam int BIT_TICKS   = CLK_FREQ / BAUD;
    localparam int FRAME_TICKS = CLK_FREQ / FRAME_RATE;
    localparam int FT_W        = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int BT_W        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

    localparam logic [FT_W-1:0] C_FRAME_LAST = FT_W'(FRAME_TICKS - 1);
    localparam logic [BT_W-1:0] C_BIT_LAST   = BT_W'(BIT_TICKS - 1);
    localparam logic [7:0]      C_SYNC       = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [FT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [BT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [63:0]      pkt_q, pkt_d;
    logic             sent_q, sent_d;
    logic             drop_q, drop_d;

    logic             w_frame_tick;
    logic             w_bit_end;
    logic [39:0]      w_payload;
    logic [7:0]       w_b6;
    logic [7:0]       w_b7;

    assign w_frame_tick = (frame_cnt_q == C_FRAME_LAST);
    assign w_bit_end    = (bit_cnt_q == C_BIT_LAST);
    assign w_payload    = {my_f_x, my_f_y, my_r_x, my_r_y};
    assign w_b6         = {state, flag, finish, 2'b00};
    assign w_b7         = w_payload[39:32] ^ w_payload[31:24] ^ w_payload[23:16]
                        ^ w_payload[15:8]  ^ w_payload[7:0]   ^ w_b6;

    always_comb begin
        frame_cnt_d = w_frame_tick ? '0 : frame_cnt_q + 1'b1;
        fsm_d       = fsm_q;
        bit_cnt_d   = w_bit_end ? '0 : bit_cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        pkt_d       = pkt_q;
        sent_d      = 1'b0;
        drop_d      = w_frame_tick && (fsm_q != S_IDLE);

        case (fsm_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (w_frame_tick) begin
                    // Byte 0 sits in the low byte so the line index is {byte, bit}.
                    pkt_d      = {w_b7, w_b6, w_payload[7:0], w_payload[15:8],
                                  w_payload[23:16], w_payload[31:24],
                                  w_payload[39:32], C_SYNC};
                    fsm_d      = S_START;
                    bit_idx_d  = 3'd0;
                    byte_idx_d = 3'd0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    fsm_d     = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        fsm_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (byte_idx_q == 3'd7) begin
                        fsm_d  = S_IDLE;
                        sent_d = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        fsm_d      = S_START;
                    end
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            frame_cnt_q <= '0;
            bit_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 3'd0;
            pkt_q       <= '0;
            sent_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            frame_cnt_q <= frame_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            pkt_q       <= pkt_d;
            sent_q      <= sent_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (fsm_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = pkt_q[{byte_idx_q, bit_idx_q}];
            default: tx = 1'b1;
        endcase
    end

    assign busy       = (fsm_q != S_IDLE);
    assign frame_sent = sent_q;
    assign frame_drop = drop_q;

endmodule
`default_nettype wire
